dpram_stream_reader: RTL and testbench
======================================

Name: dpram_stream_reader

Overview:
- Read-side engine for the 64x8 dual-port RAM: drains a block of RAM words out through one RAM port and presents them as a valid/ready stream.
- The write side (testbench or producer) fills the RAM through the other port. This block is the consumer that reads the contents back out.
- It drives the RAM port's address and write-enable, absorbs the RAM's 1-cycle registered read latency, and honours downstream backpressure without losing words.

Parameters:
- DATA_W, 8, RAM word width
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only while busy=0
- base_addr  in  ADDR_W  first address to read
- len  in  ADDR_W+1  number of words to read, 0..64
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the transfer completes
- ram_addr  out  ADDR_W  read address to the RAM port (registered)
- ram_we  out  1  RAM write enable; constant 0
- ram_q  in  DATA_W  RAM read data; valid one edge after ram_addr is sampled
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  stream word
- m_last  out  1  high with the final word of the transfer

Behaviour:
- Reset (synchronous, active-high rst=1) clears all outputs to 0 on the next edge: busy, done, ram_addr, m_valid, m_data, m_last. It also empties the in-flight tracking and the skid buffer.
- Reset takes effect mid-transfer; any RAM data that is still in flight is discarded.
- State machine:
  - IDLE to READ on start with len!=0. The edge that takes this transition is edge E0.
  - IDLE to FINISH on start with len==0. No beats are produced; done pulses for one cycle and busy stays 0.
  - READ to DRAIN once all len addresses have been issued.
  - DRAIN to FINISH once the last beat handshakes (m_valid & m_ready & m_last).
  - FINISH to IDLE after one cycle; done=1 during FINISH.
- Address generation:
  - At E0, ram_addr is loaded with base_addr.
  - Each subsequent issue increments ram_addr modulo 2**ADDR_W, so 63 wraps to 0.
- Read latency: the RAM samples ram_addr at E1 and the word is captured into the skid buffer at E2. The first m_valid is therefore high in the cycle after E2.
- Flow control:
  - A new read issues only if (buffer occupancy + reads in flight − pop this cycle) < 2. The skid buffer is 2 deep.
  - With m_ready held high, throughput is 1 word per cycle.
  - With m_ready low, at most 2 words are buffered and no further reads issue.
- Stream rules:
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_last accompanies exactly the len-th word.
- start while busy=1 is ignored.
- ram_we is tied to 0 at all times, including during reset.

Optional Feature:
- Macro: DPRAM_RD_PARITY_EN.
- With the macro defined, the block adds output m_par (1 bit), the even parity (XOR) of m_data. It is aligned with m_data, resets to 0 and is held stable under backpressure.
- Without the macro, the port and its logic are absent and the rest of the behaviour is identical.

Decomposition:
- Package dpram_rd_pkg holds:
  - the state enum: IDLE, READ, DRAIN, FINISH;
  - the default constants DATA_W=8, ADDR_W=6, and SKID_DEPTH=2.
- Sub-module dpram_rd_skid: a 2-entry buffer that stores {data, last} and has push/pop plus an occupancy output. The top level keeps the FSM, the address counter and the in-flight counter.

Test Plan:
- Preload RAM[1]=0x33, [2]=0x44, [3]=0x55, [4]=0x66. Then start base=1, len=4, m_ready=1.
  - Required: beats 0x33, 0x44, 0x55, 0x66 on consecutive cycles, with the first m_valid in the cycle after E2.
  - Required: m_last on 0x66, done one cycle after that handshake, and ram_we=0 throughout.
- Wrap-around: start base=62, len=4.
  - Required: ram_addr issues the sequence 62, 63, 0, 1, and the data order matches.
- Backpressure: same setup as the first scenario, but m_ready=0 for cycles 3..8 after start, then 1.
  - Required: ram_addr stops after 2 reads are outstanding.
  - Required: m_data holds 0x33 while stalled, and all 4 words arrive in order with none lost or duplicated.
- len=0 case:
  - Required: done pulses for one cycle, m_valid never asserts, busy stays 0.
- start is pulsed again while busy=1:
  - Required: the pulse is ignored and the transfer completes unchanged.
- rst=1 asserted mid-transfer, after 2 beats:
  - Required: all outputs are 0 on the next edge.
  - Required: a fresh start base=5, len=1 then returns only RAM[5].

Source files
------------

// File: rtl/dpram_rd_pkg.sv
// Shared types and defaults for the dual-port RAM stream reader.
// Holds the FSM state enum and the width/depth constants.
package dpram_rd_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 6;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/dpram_rd_skid.sv
// Two-entry skid buffer holding {data, last}; head is always entry 0.
// Ports: clk, rst (sync, high), i_push/i_din, i_pop, o_dout (head), o_occ.
module dpram_rd_skid
  import dpram_rd_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_din,
  input  logic             i_pop,
  output logic [W-1:0]     o_dout,
  output logic [OCC_W-1:0] o_occ
);

  logic [W-1:0]     r_d0;
  logic [W-1:0]     r_d1;
  logic [OCC_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == '0) r_d0 <= i_din;
          else             r_d1 <= i_din;
          r_cnt <= r_cnt + OCC_W'(1);
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - OCC_W'(1);
        end
        2'b11: begin
          // Simultaneous push/pop: the new word lands behind
          // whatever remains after the head leaves.
          if (r_cnt == OCC_W'(1)) begin
            r_d0 <= i_din;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout = r_d0;
  assign o_occ  = r_cnt;

endmodule

// File: rtl/dpram_stream_reader.sv
// Reads len words from the 64x8 DPRAM starting at base_addr and streams
// them out as valid/ready beats, absorbing the 1-cycle RAM read latency.
// Ports: clk, rst (sync, high); start/base_addr/len command; busy, done;
// ram_addr/ram_we/ram_q RAM port; m_valid/m_ready/m_data/m_last stream.
// Option: define DPRAM_RD_PARITY_EN to add m_par (XOR of m_data).
module dpram_stream_reader #(
  parameter int DATA_W = dpram_rd_pkg::DATA_W,
  parameter int ADDR_W = dpram_rd_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
`ifdef DPRAM_RD_PARITY_EN
  ,
  output logic              m_par
`endif
);

  import dpram_rd_pkg::*;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic              r_inflight;
  logic              r_infl_last;

  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W:0]   w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_last_issue;

  assign w_valid = (w_occ != '0);
  assign w_pop   = w_valid & m_ready;

  // A read issued now is pushed next edge, so the buffer must have a
  // free slot for it after this cycle's pop and the pending word land.
  assign w_issue = (r_state == READ) &&
                   ((int'(w_occ) + int'(r_inflight)
                     - int'(w_pop)) < SKID_DEPTH);

  assign w_last_issue = w_issue &&
                        (r_remain == (ADDR_W + 1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_remain    <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_inflight  <= w_issue;
      r_infl_last <= w_last_issue;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state  <= READ;
              r_busy   <= 1'b1;
              r_addr   <= base_addr;
              r_remain <= len;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - (ADDR_W + 1)'(1);
            if (w_last_issue) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && w_head[0]) begin
            r_state <= FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dpram_rd_skid #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .i_push(r_inflight),
    .i_din ({ram_q, r_infl_last}),
    .i_pop (w_pop),
    .o_dout(w_head),
    .o_occ (w_occ)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign ram_addr = r_addr;
  assign ram_we   = 1'b0;
  assign m_valid  = w_valid;
  assign m_data   = w_head[DATA_W:1];
  assign m_last   = w_head[0] & w_valid;

`ifdef DPRAM_RD_PARITY_EN
  assign m_par = ^m_data;
`endif

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Self-checking bench for dpram_stream_reader with a behavioural RAM
// and a reference model of the expected beat sequence.
module tb_dpram_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] len = '0;
  logic       busy, done;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q = '0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
`ifdef DPRAM_RD_PARITY_EN
  logic       m_par;
`endif

  always #5 clk = ~clk;

  dpram_stream_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_q    (ram_q),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
`ifdef DPRAM_RD_PARITY_EN
    ,
    .m_par    (m_par)
`endif
  );

  logic [7:0] mem [64];
  always @(posedge clk) ram_q <= mem[ram_addr];

  int errors = 0;
  int checks = 0;
  int we_bad = 0;
  int par_bad = 0;

  always @(negedge clk) begin
    if (ram_we !== 1'b0) we_bad++;
`ifdef DPRAM_RD_PARITY_EN
    if (m_par !== ^m_data) par_bad++;
`endif
  end

  logic       rec_valid [256];
  logic       rec_ready [256];
  logic       rec_busy  [256];
  logic [7:0] rec_data  [256];
  logic [5:0] rec_addr  [256];
  logic [7:0] bd [$];
  logic       bl [$];
  int         bc [$];
  logic [5:0] aseq [$];
  int         done_cnt, done_cyc, first_v, last_c;
  bit         timed_out;
  logic [17:0] snap;

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_xfer(input logic [5:0] b, input logic [6:0] l,
                          input int st_lo, input int st_hi,
                          input bit rnd, input int rst_after,
                          input bit repulse);
    bd.delete(); bl.delete(); bc.delete(); aseq.delete();
    done_cnt = 0; done_cyc = -1; first_v = -1; timed_out = 1;
    last_c = 0;
    @(posedge clk); #1;
    start = 1; base_addr = b; len = l; m_ready = 1;
    @(posedge clk); #1;
    start = 0; base_addr = 6'($urandom); len = 7'($urandom);
    for (int c = 1; c < 256; c++) begin
      if (rnd) m_ready = ($urandom_range(0, 2) != 0);
      else     m_ready = !(c >= st_lo && c <= st_hi);
      if (repulse && c == 2) begin
        start = 1; base_addr = b + 6'd20; len = 7'd3;
      end else begin
        start = 0;
      end
      rec_valid[c] = m_valid; rec_ready[c] = m_ready;
      rec_busy[c] = busy; rec_data[c] = m_data;
      rec_addr[c] = ram_addr; last_c = c;
      if (aseq.size() == 0 || aseq[$] !== ram_addr)
        aseq.push_back(ram_addr);
      if (m_valid && first_v < 0) first_v = c;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (m_valid && m_ready) begin
        bd.push_back(m_data); bl.push_back(m_last); bc.push_back(c);
      end
      if (rst_after > 0 && bd.size() == rst_after) begin
        @(posedge clk); #1;
        rst = 1; start = 0;
        @(posedge clk); #1;
        snap = {busy, done, ram_addr, m_valid, m_data, m_last};
        rst = 0; timed_out = 0; m_ready = 1;
        return;
      end
      if (done_cyc > 0 && c > done_cyc + 1) begin
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 0; m_ready = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ram_addr, m_valid, m_data, m_last, ram_we} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got b%0b d%0b a%0d v%0b q%0h l%0b we%0b want all 0",
               busy, done, ram_addr, m_valid, m_data, m_last, ram_we);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    logic [7:0] e;
    fill_mem();
    mem[1] = 8'h33; mem[2] = 8'h44; mem[3] = 8'h55; mem[4] = 8'h66;
    run_xfer(6'd1, 7'd4, 999, 0, 0, 0, 0);
    checks++;
    if (timed_out || bd.size() != 4) begin
      errors++;
      $display("FAIL basic_count got %0d beats to=%0b want 4", bd.size(), timed_out);
    end
    for (int i = 0; i < bd.size() && i < 4; i++) begin
      e = 8'h33 + 8'(i * 'h11);
      checks++;
      if (bd[i] !== e || bl[i] !== (i == 3) || bc[i] != 3 + i) begin
        errors++;
        $display("FAIL basic_beat%0d got %0h/l%0b@%0d want %0h/l%0b@%0d",
                 i, bd[i], bl[i], bc[i], e, i == 3, 3 + i);
      end
    end
    checks++;
    if (first_v != 3 || done_cyc != 7 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_timing got first=%0d done@%0d x%0d want 3, 7, 1",
               first_v, done_cyc, done_cnt);
    end
    checks++;
    if (rec_busy[1] !== 1'b1 || rec_busy[7] !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got c1=%0b c7=%0b want 1 0",
               rec_busy[1], rec_busy[7]);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] ea;
    fill_mem();
    run_xfer(6'd62, 7'd4, 999, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ea = 6'((62 + i) % 64);
      checks++;
      if (i >= aseq.size() || aseq[i] !== ea) begin
        errors++;
        $display("FAIL wrap_addr%0d got %0d want %0d", i,
                 (i < aseq.size()) ? aseq[i] : 6'h0, ea);
      end
      checks++;
      if (i >= bd.size() || bd[i] !== mem[(62 + i) % 64]) begin
        errors++;
        $display("FAIL wrap_data%0d got %0h want %0h", i,
                 (i < bd.size()) ? bd[i] : 8'h0, mem[(62 + i) % 64]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_mem();
    mem[1] = 8'h33; mem[2] = 8'h44; mem[3] = 8'h55; mem[4] = 8'h66;
    run_xfer(6'd1, 7'd4, 3, 8, 0, 0, 0);
    for (int c = 3; c <= 8; c++) begin
      checks++;
      if (rec_valid[c] !== 1'b1 || rec_data[c] !== 8'h33 ||
          rec_addr[c] !== 6'd3) begin
        errors++;
        $display("FAIL stall_c%0d got v%0b q%0h a%0d want v1 q33 a3",
                 c, rec_valid[c], rec_data[c], rec_addr[c]);
      end
    end
    checks++;
    if (timed_out || bd.size() != 4) begin
      errors++;
      $display("FAIL stall_count got %0d beats to=%0b want 4", bd.size(), timed_out);
    end
    for (int i = 0; i < bd.size() && i < 4; i++) begin
      checks++;
      if (bd[i] !== mem[1 + i] || bl[i] !== (i == 3)) begin
        errors++;
        $display("FAIL stall_beat%0d got %0h/l%0b want %0h/l%0b",
                 i, bd[i], bl[i], mem[1 + i], i == 3);
      end
    end
  endtask

  task automatic test_len0();
    int busy_seen;
    busy_seen = 0;
    run_xfer(6'($urandom), 7'd0, 999, 0, 0, 0, 0);
    for (int c = 1; c <= last_c; c++) if (rec_busy[c]) busy_seen++;
    checks++;
    if (timed_out || done_cnt != 1 || done_cyc != 1) begin
      errors++;
      $display("FAIL len0_done got x%0d @%0d to=%0b want x1 @1",
               done_cnt, done_cyc, timed_out);
    end
    checks++;
    if (first_v != -1 || bd.size() != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL len0_quiet got valid@%0d beats=%0d busy=%0d want none",
               first_v, bd.size(), busy_seen);
    end
  endtask

  task automatic test_restart();
    fill_mem();
    run_xfer(6'd10, 7'd5, 999, 0, 0, 0, 1);
    checks++;
    if (timed_out || bd.size() != 5 || done_cnt != 1) begin
      errors++;
      $display("FAIL restart_count got %0d beats done x%0d want 5 x1",
               bd.size(), done_cnt);
    end
    for (int i = 0; i < bd.size() && i < 5; i++) begin
      checks++;
      if (bd[i] !== mem[10 + i] || bl[i] !== (i == 4)) begin
        errors++;
        $display("FAIL restart_beat%0d got %0h want %0h",
                 i, bd[i], mem[10 + i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    fill_mem();
    run_xfer(6'd20, 7'd8, 999, 0, 0, 2, 0);
    checks++;
    if (timed_out || snap !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got %05h to=%0b want 0", snap, timed_out);
    end
    checks++;
    if (bd.size() != 2 || bd[0] !== mem[20] || bd[1] !== mem[21]) begin
      errors++;
      $display("FAIL rstmid_pre got %0d beats want 2 of %0h %0h",
               bd.size(), mem[20], mem[21]);
    end
    run_xfer(6'd5, 7'd1, 999, 0, 0, 0, 0);
    checks++;
    if (timed_out || bd.size() != 1 || bd[0] !== mem[5] ||
        bl[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fresh got %0d beats first=%0h want 1 of %0h",
               bd.size(), (bd.size() > 0) ? bd[0] : 8'h0, mem[5]);
    end
  endtask

  task automatic test_random();
    logic [5:0] b;
    logic [6:0] l;
    int         bad;
    for (int t = 0; t < 6; t++) begin
      fill_mem();
      b = 6'($urandom);
      l = 7'($urandom_range(1, 64));
      run_xfer(b, l, 0, 0, 1, 0, 0);
      checks++;
      if (timed_out || bd.size() != int'(l) || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_count got %0d beats done x%0d want %0d x1",
                 t, bd.size(), done_cnt, l);
      end
      bad = 0;
      for (int i = 0; i < bd.size(); i++)
        if (bd[i] !== mem[(int'(b) + i) % 64] ||
            bl[i] !== (i == int'(l) - 1)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand%0d_data got %0d bad beats want 0", t, bad);
      end
      bad = 0;
      for (int c = 1; c < last_c; c++)
        if (rec_valid[c] && !rec_ready[c] &&
            (rec_valid[c + 1] !== 1'b1 || rec_data[c + 1] !== rec_data[c]))
          bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand%0d_hold got %0d unstable stalls want 0", t, bad);
      end
    end
  endtask

  task automatic test_static();
    checks++;
    if (we_bad != 0) begin
      errors++;
      $display("FAIL ram_we got %0d high samples want 0", we_bad);
    end
    checks++;
    if (par_bad != 0) begin
      errors++;
      $display("FAIL parity got %0d bad samples want 0", par_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_restart();
    test_rst_mid();
    test_random();
    test_static();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
